// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle instruction sequencer.
package multicycle_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  // Opcode map (IR[15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_ANDI = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_XORI = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BLT  = 4'hC;
  localparam logic [3:0] OP_BGT  = 4'hD;
  localparam logic [3:0] OP_BLE  = 4'hE;
  localparam logic [3:0] OP_BGE  = 4'hF;

  // PC source select
  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Memory address source
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  // Opcodes 0..7 are register/immediate ALU operations
  function automatic logic is_alu_op(input logic [3:0] op);
    return ~op[3];
  endfunction

  // Loads and stores take the extra MEM state
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the sequencer and the datapath it steers.
// master = sequencer, slave = datapath / memory side.
interface multicycle_sequencer_if #(
  parameter int RET_W = 16
);

  // Datapath status into the sequencer
  logic             run;
  logic [3:0]       opcode;
  logic             greater;
  logic             less;
  logic             equal;
  logic             mem_ready;

  // Control strobes and selects out of the sequencer
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic             reg_write;
  logic             imm_sel;
  logic [1:0]       alu_ctrl;
  logic             mem_load;
  logic             mem_store;
  logic             addr_sel;
  logic             busy;
  logic             mem_err;
  logic [RET_W-1:0] retired;

  modport master (
    input  run, opcode, greater, less, equal, mem_ready,
    output pc_we, pc_src, ir_we, reg_write, imm_sel, alu_ctrl,
           mem_load, mem_store, addr_sel, busy, mem_err, retired
  );

  modport slave (
    output run, opcode, greater, less, equal, mem_ready,
    input  pc_we, pc_src, ir_we, reg_write, imm_sel, alu_ctrl,
           mem_load, mem_store, addr_sel, busy, mem_err, retired
  );

endinterface

// File: rtl/multicycle_sequencer_branch_resolver.sv
// Decides whether a conditional branch opcode is taken from the ALU compare flags.
module multicycle_sequencer_branch_resolver
  import multicycle_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       equal,
  input  logic       less,
  input  logic       greater,
  output logic       taken
);

  // Map each branch opcode to its flag condition; non-branches are never taken
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = equal;
      OP_BLT:  taken = less;
      OP_BGT:  taken = greater;
      OP_BLE:  taken = equal | less;
      OP_BGE:  taken = equal | greater;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-opcode datapath.
// Holds each memory request until mem_ready, aborting to IDLE with a sticky
// error if the memory stays silent for MEM_TIMEOUT request cycles.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 16
) (
  input  logic                   clock,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  // The counter only has to reach MEM_TIMEOUT-1: the cycle that would make
  // it MEM_TIMEOUT is the abort cycle itself.
  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        opcode_q;
  logic [WAIT_W-1:0] wait_q;
  logic              mem_err_q;
  logic [RET_W-1:0]  retired_q;

  logic              in_access;
  logic              wait_last;
  logic              abort;
  logic              instr_end;
  logic              taken;

  assign in_access = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_last = (wait_q == WAIT_LAST);

  multicycle_sequencer_branch_resolver u_branch (
    .opcode  (opcode_q),
    .equal   (bus.equal),
    .less    (bus.less),
    .greater (bus.greater),
    .taken   (taken)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; also flags instruction completion and timeout abort
  always_comb begin
    state_d   = state_q;
    instr_end = 1'b0;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run && !mem_err_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_last) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu_op(opcode_q)) begin
          state_d = S_WB;
        end else if (is_mem_op(opcode_q)) begin
          state_d = S_MEM;
        end else begin
          instr_end = 1'b1;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (opcode_q == OP_LD) state_d = S_WB;
          else                   instr_end = 1'b1;
        end else if (wait_last) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        instr_end = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // run is only looked at on an instruction boundary
    if (instr_end) state_d = bus.run ? S_FETCH : S_IDLE;
  end

  // Opcode latch, memory wait counter, sticky error and retire counter
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      opcode_q  <= 4'h0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (state_q == S_DECODE) opcode_q <= bus.opcode;
      if (in_access && !bus.mem_ready && !abort) wait_q <= wait_q + 1'b1;
      else                                       wait_q <= '0;
      if (abort)     mem_err_q <= 1'b1;
      if (instr_end) retired_q <= retired_q + 1'b1;
    end
  end

  // Control outputs from registered state and latched opcode; mem_ready only
  // gates the single-cycle completion strobes (IR load, store-completion PC)
  always_comb begin
    bus.pc_we     = 1'b0;
    bus.pc_src    = PC_SRC_INC;
    bus.ir_we     = 1'b0;
    bus.reg_write = 1'b0;
    bus.imm_sel   = 1'b0;
    bus.alu_ctrl  = ALU_ADD;
    bus.mem_load  = 1'b0;
    bus.mem_store = 1'b0;
    bus.addr_sel  = ADDR_PC;
    case (state_q)
      S_FETCH: begin
        bus.mem_load = 1'b1;
        bus.addr_sel = ADDR_PC;
        bus.ir_we    = bus.mem_ready;
      end
      S_EXEC: begin
        if (is_alu_op(opcode_q)) begin
          bus.alu_ctrl = opcode_q[2:1];
          bus.imm_sel  = opcode_q[0];
        end else if (opcode_q == OP_JMP) begin
          bus.pc_we  = 1'b1;
          bus.pc_src = PC_SRC_JUMP;
        end else if (is_mem_op(opcode_q)) begin
          // Effective address = base register + immediate
          bus.alu_ctrl = ALU_ADD;
          bus.imm_sel  = 1'b1;
        end else begin
          bus.pc_we  = 1'b1;
          bus.pc_src = taken ? PC_SRC_BRANCH : PC_SRC_INC;
        end
      end
      S_MEM: begin
        bus.addr_sel = ADDR_ALU;
        if (opcode_q == OP_LD) begin
          bus.mem_load = 1'b1;
        end else begin
          bus.mem_store = 1'b1;
          // A store finishes in MEM, so the PC advances on the accepting cycle
          bus.pc_we     = bus.mem_ready;
          bus.pc_src    = PC_SRC_INC;
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_we     = 1'b1;
        bus.pc_src    = PC_SRC_INC;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.mem_err = mem_err_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer: table-driven instruction vectors, random
// instructions against a per-instruction reference model, and hand-written
// sequences for timeout, run-drop and reset-during-access.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int RET_W = 16;
  localparam int TMO   = 4;

  logic             clock = 1'b0;
  logic             rst_n;
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [RET_W-1:0] exp_ret;

  multicycle_sequencer_if #(.RET_W(RET_W)) bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .RET_W(RET_W)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // One instruction: stimulus plus expected per-instruction behaviour
  typedef struct {
    logic [3:0] op;
    logic       eq;
    logic       lt;
    logic       gt;
    int         wf;      // fetch wait cycles before mem_ready
    int         wm;      // data wait cycles before mem_ready
    int         cycles;  // total cycles FETCH .. instruction end
    int         src;     // pc_src on the pc_we cycle
    int         regw;    // number of reg_write cycles
    int         chk_alu; // 1: check alu_ctrl/imm_sel in EXEC
    int         alu;
    int         imm;
    int         loads;   // cycles with mem_load
    int         stores;  // cycles with mem_store
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int outs();
    return int'({bus.pc_we, bus.pc_src, bus.ir_we, bus.reg_write, bus.imm_sel,
                 bus.alu_ctrl, bus.mem_load, bus.mem_store, bus.addr_sel,
                 bus.busy, bus.mem_err, bus.retired});
  endfunction

  // Reference model: what one instruction should do, from the ISA rules,
  // given two compared operand values and the memory wait times.
  function automatic vec_t model(input logic [3:0] op, input int a, input int b,
                                 input int wf, input int wm);
    vec_t v;
    bit   alu_op, ld, st, jmp, taken;
    alu_op = (op < 4'h8);
    jmp    = (op == 4'h8);
    ld     = (op == 4'h9);
    st     = (op == 4'hA);
    case (op)
      4'hB:    taken = (a == b);
      4'hC:    taken = (a < b);
      4'hD:    taken = (a > b);
      4'hE:    taken = (a <= b);
      4'hF:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
    v.op      = op;
    v.eq      = (a == b);
    v.lt      = (a < b);
    v.gt      = (a > b);
    v.wf      = wf;
    v.wm      = wm;
    v.cycles  = (wf + 1) + 2 + ((ld || st) ? wm + 1 : 0) + ((alu_op || ld) ? 1 : 0);
    v.src     = jmp ? 1 : (taken ? 2 : 0);
    v.regw    = (alu_op || ld) ? 1 : 0;
    v.chk_alu = (alu_op || ld || st) ? 1 : 0;
    v.alu     = alu_op ? int'(op) / 2 : 0;
    v.imm     = alu_op ? int'(op) % 2 : 1;
    v.loads   = (wf + 1) + (ld ? wm + 1 : 0);
    v.stores  = st ? wm + 1 : 0;
    return v;
  endfunction

  // Run one instruction starting in FETCH; memory answers after the planned waits
  task automatic run_instr(input string tag, input vec_t v);
    int req = 0;
    int n_ir = 0, ir_at = -1, n_pc = 0, pc_at = -1, src = -1;
    int n_rw = 0, rw_at = -1, n_ld = 0, n_st = 0, n_both = 0, n_idle = 0;
    int alu_seen = -1, imm_seen = -1;
    bus.opcode  = v.op;
    bus.equal   = v.eq;
    bus.less    = v.lt;
    bus.greater = v.gt;
    for (int i = 0; i < v.cycles; i++) begin
      bus.mem_ready = 1'b0;
      if (bus.mem_load || bus.mem_store) begin
        req++;
        if (req > (bus.addr_sel ? v.wm : v.wf)) begin
          bus.mem_ready = 1'b1;
          req = 0;
        end
      end
      #1;
      if (bus.ir_we) begin n_ir++; ir_at = i; end
      if (bus.pc_we) begin n_pc++; pc_at = i; src = int'(bus.pc_src); end
      if (bus.reg_write) begin n_rw++; rw_at = i; end
      if (bus.mem_load) n_ld++;
      if (bus.mem_store) n_st++;
      if (bus.mem_load && bus.mem_store) n_both++;
      if (!bus.busy) n_idle++;
      if (i == v.wf + 2) begin
        alu_seen = int'(bus.alu_ctrl);
        imm_seen = int'(bus.imm_sel);
      end
      tick();
    end
    bus.mem_ready = 1'b0;
    exp_ret = exp_ret + 1'b1;
    check({tag, ".ir_we_count"}, n_ir, 1);
    check({tag, ".ir_we_cycle"}, ir_at, v.wf);
    check({tag, ".pc_we_count"}, n_pc, 1);
    check({tag, ".pc_we_cycle"}, pc_at, v.cycles - 1);
    check({tag, ".pc_src"}, src, v.src);
    check({tag, ".reg_write_count"}, n_rw, v.regw);
    if (v.regw != 0) check({tag, ".reg_write_cycle"}, rw_at, v.cycles - 1);
    check({tag, ".load_cycles"}, n_ld, v.loads);
    check({tag, ".store_cycles"}, n_st, v.stores);
    check({tag, ".load_store_overlap"}, n_both, 0);
    check({tag, ".idle_cycles"}, n_idle, 0);
    if (v.chk_alu != 0) begin
      check({tag, ".alu_ctrl"}, alu_seen, v.alu);
      check({tag, ".imm_sel"}, imm_seen, v.imm);
    end
    check({tag, ".retired"}, int'(bus.retired), int'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_req, n_wr, n_busy;
    vec_t v;

    //              op    eq    lt    gt   wf wm cyc src rw chk alu imm ld st
    tbl[0]  = '{4'h1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1, 0, 1, 1, 0};
    tbl[1]  = '{4'h9, 1'b0, 1'b0, 1'b0, 0, 3, 8, 0, 1, 1, 0, 1, 5, 0};
    tbl[2]  = '{4'hE, 1'b0, 1'b1, 1'b0, 0, 0, 3, 2, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{4'hF, 1'b0, 1'b1, 1'b0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{4'hB, 1'b0, 1'b1, 1'b0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0};
    tbl[5]  = '{4'hA, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 0, 1, 0, 1, 1, 1};
    tbl[6]  = '{4'h8, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0};
    tbl[7]  = '{4'h6, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1, 3, 0, 1, 0};
    tbl[8]  = '{4'h5, 1'b0, 1'b0, 1'b0, 2, 0, 6, 0, 1, 1, 2, 1, 3, 0};
    tbl[9]  = '{4'hC, 1'b0, 1'b1, 1'b0, 0, 0, 3, 2, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{4'hD, 1'b1, 1'b0, 1'b0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{4'hA, 1'b0, 1'b0, 1'b0, 3, 3, 10, 0, 0, 1, 0, 1, 4, 4};

    // Reset state
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.opcode    = 4'h0;
    bus.equal     = 1'b0;
    bus.less      = 1'b0;
    bus.greater   = 1'b0;
    bus.mem_ready = 1'b0;
    exp_ret       = '0;
    tick(); tick(); tick();
    check("reset.outputs", outs(), 0);
    rst_n = 1'b1;
    tick();
    check("idle_no_run.busy", int'(bus.busy), 0);
    bus.run = 1'b1;
    tick();
    check("fetch_entry.mem_load", int'(bus.mem_load), 1);

    // Table-driven instructions, back to back with run held high
    for (int i = 0; i < 12; i++) run_instr($sformatf("tbl%0d", i), tbl[i]);

    // Random instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      v = model(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      run_instr($sformatf("rnd%0d", i), v);
    end

    // run dropped in EXEC of ADD: WB still completes, then IDLE
    bus.opcode    = OP_ADD;
    bus.mem_ready = 1'b1;
    #1;
    check("rundrop.ir_we", int'(bus.ir_we), 1);
    tick();
    bus.mem_ready = 1'b0;
    tick();
    bus.run = 1'b0;
    #1;
    check("rundrop.exec_alu", int'(bus.alu_ctrl), 0);
    check("rundrop.exec_imm", int'(bus.imm_sel), 0);
    tick();
    check("rundrop.wb_reg_write", int'(bus.reg_write), 1);
    check("rundrop.wb_pc_we", int'(bus.pc_we), 1);
    tick();
    exp_ret = exp_ret + 1'b1;
    check("rundrop.busy_after", int'(bus.busy), 0);
    check("rundrop.retired", int'(bus.retired), int'(exp_ret));
    tick();
    check("rundrop.stays_idle", int'(bus.busy), 0);

    // Fetch timeout: memory never answers
    bus.run = 1'b1;
    tick();
    n_req = 0;
    n_wr  = 0;
    for (int c = 0; c < 12 && bus.busy; c++) begin
      #1;
      if (bus.mem_load) n_req++;
      if (bus.ir_we || bus.pc_we || bus.reg_write) n_wr++;
      tick();
    end
    check("timeout.request_cycles", n_req, TMO);
    check("timeout.writes", n_wr, 0);
    check("timeout.busy", int'(bus.busy), 0);
    check("timeout.mem_err", int'(bus.mem_err), 1);
    check("timeout.retired", int'(bus.retired), int'(exp_ret));
    n_busy = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.busy || bus.mem_load) n_busy++;
      tick();
    end
    check("timeout.parked_cycles_busy", n_busy, 0);
    check("timeout.mem_err_sticky", int'(bus.mem_err), 1);

    // Reset clears the sticky error
    rst_n = 1'b0;
    tick();
    check("reset2.mem_err", int'(bus.mem_err), 0);
    check("reset2.retired", int'(bus.retired), 0);
    exp_ret = '0;
    rst_n = 1'b1;
    tick();
    check("reset2.refetch", int'(bus.mem_load), 1);

    // Reset during a fetch wait drops the request
    tick();
    check("fetchwait.still_loading", int'(bus.mem_load), 1);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    check("fetchwait_reset.outputs", outs(), 0);
    rst_n         = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
